// File: rtl/dot_feed.sv
// Purpose : feeds signed operand-pair products to the accumulate/output stage, one dot product per start.
// Latency : product appears 1 cycle after its accept; isStop/done 2 cycles after the final accept.
// Backpr. : valid/ready on the operand stream; in_ready is high only in RUN while pairs remain.
//
// Ports:
//   clk, rst (sync, active-low)      - clock and reset
//   start, len, abort                - run control; len captured when start is taken in IDLE
//   a_data, b_data, in_valid/ready   - signed operand-pair stream
//   data, sig, isStop, clear_reg     - downstream accumulator interface (sig 001 = accumulate)
//   busy, done                       - status; done pulses together with isStop
module dot_feed #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       data,
    output logic [2:0]        sig,
    output logic              isStop,
    output logic              clear_reg,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_STOP
    } state_t;

    localparam logic [2:0] SIG_NOP = 3'b000;
    localparam logic [2:0] SIG_ACC = 3'b001;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   cnt_inc;
    logic [31:0]        data_q, data_d;
    logic [2:0]         sig_q, sig_d;
    logic               in_ready_q, in_ready_d;
    logic               clear_q, clear_d;
    logic               stop_q, stop_d;
    logic               done_q;
    logic               busy_q, busy_d;
    logic               accept;

    logic signed [2*DATA_W-1:0] prod;

    // Full-precision signed product, then sign-extended to the 32-bit data bus.
    assign prod    = $signed(a_data) * $signed(b_data);
    assign cnt_inc = cnt_q + LEN_W'(1);
    // in_ready_q is only ever set in RUN, so this is an accept in RUN.
    assign accept  = in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        data_d     = data_q;      // data only moves together with a sig=001 cycle
        sig_d      = SIG_NOP;
        in_ready_d = 1'b0;
        clear_d    = 1'b0;
        stop_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort is ignored here, so start wins when both are high
                if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    clear_d = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    clear_d = 1'b1;
                    state_d = S_IDLE;
                end else if (len_q == '0) begin
                    stop_d  = 1'b1;
                    state_d = S_STOP;
                end else begin
                    in_ready_d = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                // abort beats a same-cycle accept: the pair is left unconsumed
                if (abort) begin
                    clear_d = 1'b1;
                    state_d = S_IDLE;
                end else if (accept) begin
                    cnt_d  = cnt_inc;
                    data_d = 32'(prod);
                    sig_d  = SIG_ACC;
                    if (cnt_inc == len_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        in_ready_d = 1'b1;
                    end
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            S_DRAIN: begin
                // last product is on the bus this cycle; isStop follows one edge later
                if (abort) begin
                    clear_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    stop_d  = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            sig_q      <= SIG_NOP;
            in_ready_q <= 1'b0;
            clear_q    <= 1'b0;
            stop_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            sig_q      <= sig_d;
            in_ready_q <= in_ready_d;
            clear_q    <= clear_d;
            stop_q     <= stop_d;
            done_q     <= stop_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign data      = data_q;
    assign sig       = sig_q;
    assign isStop    = stop_q;
    assign clear_reg = clear_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dot_feed.sv
// Purpose : self-checking bench for dot_feed with a timing-rule reference model and a downstream accumulator model.
// Latency : n/a (testbench).
// Backpr. : drives in_valid per run mode; expected in_ready derived from the run rules, not from the DUT.
module tb_dot_feed;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       data;
    logic [2:0]        sig;
    logic              isStop;
    logic              clear_reg;
    logic              busy;
    logic              done;

    int          checks   = 0;
    int          failures = 0;
    int          pa [256];
    int          pb [256];
    logic [31:0] last_data;
    logic [31:0] ds_acc;

    dot_feed #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .a_data   (a_data),
        .b_data   (b_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data     (data),
        .sig      (sig),
        .isStop   (isStop),
        .clear_reg(clear_reg),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Downstream accumulate/output stage as seen at the end of a sampled cycle.
    task automatic ds_update();
        if (clear_reg)          ds_acc = 32'd0;
        else if (sig == 3'b001) ds_acc = ds_acc + data;
    endtask

    task automatic fill_random(input int n);
        logic signed [15:0] r;
        for (int i = 0; i < n; i++) begin
            r = 16'($urandom); pa[i] = r;
            r = 16'($urandom); pb[i] = r;
        end
    endtask

    // One run: cycle t=0 is the start cycle. vmode 0: valid always, 1: 1,0,0 pattern, 2: random.
    // abort_acc >= 0 raises abort on the first cycle (after start) where that many pairs are taken.
    task automatic do_run(input int n, input int vmode, input int abort_acc);
        int   acc, stop_t, sum;
        bit   ab, v, exp_rdy, acc_now, fin;
        bit   exp_clr, exp_stp, exp_rdy_n, exp_busy;
        logic [31:0] exp_data;
        logic [2:0]  exp_sig;
        acc = 0; sum = 0; fin = 0;
        stop_t = (n == 0) ? 2 : -1;
        for (int t = 0; t < 3000 && !fin; t++) begin
            @(negedge clk);
            exp_rdy = (t >= 2) && (acc < n);
            ab = (abort_acc >= 0) && (t >= 1) && (acc == abort_acc);
            case (vmode)
                0:       v = 1'b1;
                1:       v = (t >= 2) && (((t - 2) % 3) == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            start    = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            len      = (t == 0) ? LEN_W'(n) : LEN_W'($urandom);
            abort    = ab;
            in_valid = v;
            a_data   = (acc < n) ? 16'(pa[acc]) : 16'($urandom);
            b_data   = (acc < n) ? 16'(pb[acc]) : 16'($urandom);
            acc_now  = v && exp_rdy && !ab;
            @(posedge clk); #1;
            exp_sig  = 3'b000;
            exp_data = last_data;
            if (acc_now) begin
                exp_data = 32'(pa[acc] * pb[acc]);
                exp_sig  = 3'b001;
                sum      = sum + pa[acc] * pb[acc];
                acc++;
                if (acc == n) stop_t = t + 2;
            end
            exp_clr   = (t == 0) || ab;
            exp_stp   = !ab && (t + 1 == stop_t);
            exp_rdy_n = !ab && (t + 1 >= 2) && (acc < n);
            exp_busy  = !ab && ((stop_t < 0) || (t + 1 <= stop_t));
            if (exp_stp) check("ds_sum", ds_acc, 32'(sum));
            check("sig",       32'(sig),       32'(exp_sig));
            check("data",      data,           exp_data);
            check("clear_reg", 32'(clear_reg), 32'(exp_clr));
            check("isStop",    32'(isStop),    32'(exp_stp));
            check("done",      32'(done),      32'(exp_stp));
            check("in_ready",  32'(in_ready),  32'(exp_rdy_n));
            check("busy",      32'(busy),      32'(exp_busy));
            ds_update();
            last_data = exp_data;
            if (ab || (t + 1 == stop_t)) fin = 1;
        end
        check("run_end", 32'(fin), 32'd1);
        @(negedge clk);
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("post_busy",   32'(busy),      32'd0);
        check("post_stop",   32'(isStop),    32'd0);
        check("post_clear",  32'(clear_reg), 32'd0);
        check("post_sig",    32'(sig),       32'd0);
        check("post_data",   data,           last_data);
        ds_update();
    endtask

    initial begin
        int n, ab;
        rst = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
        a_data = '0; b_data = '0; in_valid = 1'b0;
        last_data = 32'd0; ds_acc = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",  data,            32'd0);
        check("rst_sig",   32'(sig),        32'd0);
        check("rst_stop",  32'(isStop),     32'd0);
        check("rst_clear", 32'(clear_reg),  32'd0);
        check("rst_ready", 32'(in_ready),   32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        @(negedge clk); rst = 1'b1;

        // IDLE ignores valid data and abort
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; abort = 1'(i & 1); a_data = 16'($urandom); b_data = 16'($urandom);
            @(posedge clk); #1;
            check("idle_ready", 32'(in_ready), 32'd0);
            check("idle_sig",   32'(sig),      32'd0);
            check("idle_busy",  32'(busy),     32'd0);
        end
        @(negedge clk); in_valid = 1'b0; abort = 1'b0;

        pa[0] = 2;  pb[0] = 5;  pa[1] = 3; pb[1] = 6; pa[2] = 4; pb[2] = 7;
        do_run(3, 0, -1);
        pa[0] = -3; pb[0] = 7;  pa[1] = -32768; pb[1] = -32768;
        do_run(2, 0, -1);
        for (int i = 0; i < 4; i++) begin pa[i] = i + 1; pb[i] = i + 1; end
        do_run(4, 1, -1);
        do_run(0, 0, -1);
        fill_random(5);
        do_run(5, 0, 2);
        pa[0] = 6; pb[0] = 7;
        do_run(1, 0, -1);
        fill_random(3);
        do_run(3, 0, 0);     // abort in CLEAR
        fill_random(3);
        do_run(3, 0, 3);     // abort in DRAIN

        // reset mid-run, with a start during RUN that must be ignored
        @(negedge clk); start = 1'b1; len = 8'd5;
        @(negedge clk); start = 1'b0;
        @(negedge clk); in_valid = 1'b1; a_data = 16'd3; b_data = 16'd3; start = 1'b1; len = 8'd2;
        @(negedge clk); start = 1'b0;
        check("mid_sig",  32'(sig), 32'd1);
        check("mid_data", data,     32'd9);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mrst_data",  data,           32'd0);
        check("mrst_sig",   32'(sig),       32'd0);
        check("mrst_stop",  32'(isStop),    32'd0);
        check("mrst_clear", 32'(clear_reg), 32'd0);
        check("mrst_ready", 32'(in_ready),  32'd0);
        check("mrst_busy",  32'(busy),      32'd0);
        check("mrst_done",  32'(done),      32'd0);
        @(negedge clk); rst = 1'b1; in_valid = 1'b0;
        last_data = 32'd0; ds_acc = 32'd0;

        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 10);
            fill_random(n);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
            do_run(n, 2, ab);
        end
        fill_random(255);
        do_run(255, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
